// File: rtl/spi_sensor_arbiter_if.sv
// spi_sensor_arbiter_if: command/response bundle between the arbiter and the shared SPI engine
interface spi_sensor_arbiter_if;
   logic       eng_send;
   logic       eng_rw;
   logic [6:0] eng_reg;
   logic [7:0] eng_wdata;
   logic [7:0] eng_rdata;
   logic       eng_done;
   logic       eng_abort;
   logic [3:0] sel;
   modport master (output eng_send, eng_rw, eng_reg, eng_wdata, eng_abort, sel,
                   input eng_rdata, eng_done);
   modport slave  (input eng_send, eng_rw, eng_reg, eng_wdata, eng_abort, sel,
                   output eng_rdata, eng_done);
endinterface

// File: rtl/spi_sensor_arbiter.sv
// spi_sensor_arbiter: round-robin sharing of one SPI engine among four sensor requesters with watchdog abort
module spi_sensor_arbiter #(
   parameter int          NUM_REQ = 4,
   parameter logic [31:0] TIMEOUT = 32'd20000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     req_rw,
   input  logic [7*NUM_REQ-1:0]   req_reg,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   output logic [8*NUM_REQ-1:0]   req_rdata,
   output logic [NUM_REQ-1:0]     req_done,
   output logic [NUM_REQ-1:0]     req_pending,
   output logic [NUM_REQ-1:0]     req_err,
   input  logic                   err_clr,
   spi_sensor_arbiter_if.master   eng
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t          state;
   logic [1:0]      grant, last, pick;
   logic [31:0]     wd;
   logic [3:0]      slot_rw;
   logic [3:0][6:0] slot_reg;
   logic [3:0][7:0] slot_wd;
   logic [3:0]      gmask, clr, pend_eff, accept, drop, tout;
   always_comb begin
      pick = last + 2'd1;
      for (int k = 4; k >= 1; k--)
         if (req_pending[last + 2'(k)]) pick = last + 2'(k);
      gmask    = 4'b1 << grant;
      // a completing slot frees up before same-cycle requests are judged
      clr      = (state == DONE) ? gmask : '0;
      pend_eff = req_pending & ~clr;
      accept   = req & ~pend_eff;
      drop     = req & pend_eff;
      tout     = (state == WAIT && wd == TIMEOUT - 32'd1) ? gmask : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         grant         <= '0;
         last          <= 2'd3;
         wd            <= '0;
         slot_rw       <= '0;
         slot_reg      <= '0;
         slot_wd       <= '0;
         req_pending   <= '0;
         req_done      <= '0;
         req_err       <= '0;
         req_rdata     <= '0;
         eng.eng_send  <= 1'b0;
         eng.eng_abort <= 1'b0;
         eng.eng_rw    <= 1'b0;
         eng.eng_reg   <= '0;
         eng.eng_wdata <= '0;
         eng.sel       <= '0;
      end else begin
         req_pending   <= pend_eff | accept;
         req_err       <= (req_err & ~{4{err_clr}}) | drop | tout;
         req_done      <= '0;
         eng.eng_send  <= 1'b0;
         eng.eng_abort <= 1'b0;
         for (int i = 0; i < 4; i++)
            if (accept[i]) begin
               slot_rw[i]  <= req_rw[i];
               slot_reg[i] <= req_reg[7*i +: 7];
               slot_wd[i]  <= req_wdata[8*i +: 8];
            end
         case (state)
            IDLE: if (|req_pending) begin
               grant         <= pick;
               eng.sel       <= 4'b1 << pick;
               eng.eng_rw    <= slot_rw[pick];
               eng.eng_reg   <= slot_reg[pick];
               eng.eng_wdata <= slot_wd[pick];
               eng.eng_send  <= 1'b1;
               state         <= ISSUE;
            end
            ISSUE: begin
               wd    <= '0;
               state <= WAIT;
            end
            WAIT: begin
               wd <= wd + {31'b0, ~&wd};
               // registered one cycle early so the abort lands exactly TIMEOUT after the send
               eng.eng_abort <= (wd == TIMEOUT - 32'd2) && !eng.eng_done;
               if (|tout || eng.eng_done) begin
                  if (~|tout && eng.eng_rw) req_rdata[8*grant +: 8] <= eng.eng_rdata;
                  req_done <= gmask;
                  state    <= DONE;
               end
            end
            DONE: begin
               last          <= grant;
               eng.sel       <= '0;
               eng.eng_rw    <= 1'b0;
               eng.eng_reg   <= '0;
               eng.eng_wdata <= '0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_sensor_arbiter.sv
// tb_spi_sensor_arbiter: directed checks of grant order, timing, drop errors, watchdog and reset
module tb_spi_sensor_arbiter;
   localparam logic [31:0] TO = 32'd50;
   logic        clk = 1'b0, reset = 1'b1, err_clr = 1'b0;
   logic [3:0]  req = '0, req_rw = '0;
   logic [27:0] req_reg = '0;
   logic [31:0] req_wdata = '0, req_rdata;
   logic [3:0]  req_done, req_pending, req_err;
   int          vectors = 0, errs = 0, n;
   spi_sensor_arbiter_if eng();
   spi_sensor_arbiter #(.NUM_REQ(4), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_reg(req_reg),
      .req_wdata(req_wdata), .req_rdata(req_rdata), .req_done(req_done),
      .req_pending(req_pending), .req_err(req_err), .err_clr(err_clr), .eng(eng));
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic serve(input string tag, input logic [3:0] s, input logic [7:0] w,
                        input logic [6:0] r, input logic rw, input int lat,
                        input logic [7:0] rd, output int cnt);
      cnt = 0;
      while (!eng.eng_send && cnt < 100) begin step; cnt++; end
      chk({tag, "_send"}, {31'b0, eng.eng_send}, 1);
      chk({tag, "_sel"}, {28'b0, eng.sel}, {28'b0, s});
      chk({tag, "_wdata"}, {24'b0, eng.eng_wdata}, {24'b0, w});
      chk({tag, "_reg"}, {25'b0, eng.eng_reg}, {25'b0, r});
      chk({tag, "_rw"}, {31'b0, eng.eng_rw}, {31'b0, rw});
      step;
      repeat (lat) step;
      eng.eng_done = 1'b1;
      eng.eng_rdata = rd;
      step;
      eng.eng_done = 1'b0;
      chk({tag, "_done"}, {28'b0, req_done}, {28'b0, s});
   endtask
   initial begin
      eng.eng_done = 1'b0;
      eng.eng_rdata = '0;
      repeat (2) step;
      chk("rst_pending", {28'b0, req_pending}, 0);
      chk("rst_sel", {28'b0, eng.sel}, 0);
      chk("rst_send", {31'b0, eng.eng_send}, 0);
      chk("rst_rdata", req_rdata, 0);
      reset = 1'b0;
      // all four at once: 0,1,2,3 after reset
      req = 4'hF; req_wdata = 32'h13121110; step; req = '0;
      chk("rr_pending", {28'b0, req_pending}, 32'hF);
      serve("rr0", 4'b0001, 8'h10, 7'h00, 1'b0, 3, 8'h00, n);
      chk("rr0_latency", n, 1);
      serve("rr1", 4'b0010, 8'h11, 7'h00, 1'b0, 3, 8'h00, n);
      chk("rr1_gap", n, 2);
      serve("rr2", 4'b0100, 8'h12, 7'h00, 1'b0, 3, 8'h00, n);
      serve("rr3", 4'b1000, 8'h13, 7'h00, 1'b0, 3, 8'h00, n);
      req = 4'b0101; req_wdata = 32'h00220020; step; req = '0;
      serve("rr_a", 4'b0001, 8'h20, 7'h00, 1'b0, 2, 8'h00, n);
      serve("rr_b", 4'b0100, 8'h22, 7'h00, 1'b0, 2, 8'h00, n);
      // single read on requester 1
      req = 4'b0010; req_rw = 4'b0010; req_reg = 28'h0F << 7; step; req = '0;
      chk("rd_pending", {28'b0, req_pending}, 32'h2);
      serve("rd", 4'b0010, 8'h00, 7'h0F, 1'b1, 40, 8'hB1, n);
      chk("rd_latency", n, 1);
      chk("rd_data", {24'b0, req_rdata[15:8]}, 32'hB1);
      chk("rd_sel_held", {28'b0, eng.sel}, 32'h2);
      chk("rd_no_abort", {31'b0, eng.eng_abort}, 0);
      step;
      chk("rd_sel_clear", {28'b0, eng.sel}, 0);
      chk("rd_reg_clear", {25'b0, eng.eng_reg}, 0);
      // dropped request keeps original fields
      req = 4'b0100; req_rw = '0; req_reg = 28'h22 << 14; req_wdata = 32'h00550000; step;
      req_reg = 28'h33 << 14; req_wdata = 32'h00660000; step;
      chk("drop_send", {31'b0, eng.eng_send}, 1);
      chk("drop_wdata", {24'b0, eng.eng_wdata}, 32'h55);
      chk("drop_reg", {25'b0, eng.eng_reg}, 32'h22);
      chk("drop_err", {28'b0, req_err}, 32'h4);
      step; req = '0;
      chk("drop_err2", {28'b0, req_err}, 32'h4);
      repeat (2) step;
      eng.eng_done = 1'b1; step; eng.eng_done = 1'b0;
      chk("drop_done", {28'b0, req_done}, 32'h4);
      step;
      chk("drop_single", {28'b0, req_done}, 0);
      step;
      chk("drop_idle", {28'b0, req_pending}, 0);
      err_clr = 1'b1; step; err_clr = 1'b0;
      chk("err_clr", {28'b0, req_err}, 0);
      // timeout on requester 3 after a good read
      req = 4'b1000; req_rw = 4'b1000; req_reg = 28'h11 << 21; step; req = '0;
      serve("rd3", 4'b1000, 8'h00, 7'h11, 1'b1, 2, 8'h5A, n);
      chk("rd3_data", {24'b0, req_rdata[31:24]}, 32'h5A);
      req = 4'b1000; step; req = '0; step;
      chk("to_send", {31'b0, eng.eng_send}, 1);
      n = 0;
      while (!eng.eng_abort && n < 200) begin step; n++; end
      chk("to_abort_cycle", n, TO);
      step;
      chk("to_abort_pulse", {31'b0, eng.eng_abort}, 0);
      chk("to_done", {28'b0, req_done}, 32'h8);
      chk("to_err", {28'b0, req_err}, 32'h8);
      chk("to_rdata", {24'b0, req_rdata[31:24]}, 32'h5A);
      eng.eng_done = 1'b1; eng.eng_rdata = 8'hEE; step; eng.eng_done = 1'b0; step;
      chk("late_done_rdata", {24'b0, req_rdata[31:24]}, 32'h5A);
      chk("late_done_pulse", {28'b0, req_done}, 0);
      // reset while a transaction is in flight
      req = 4'b0110; req_rw = '0; step; req = '0;
      repeat (3) step;
      reset = 1'b1; step; reset = 1'b0;
      chk("mr_pending", {28'b0, req_pending}, 0);
      chk("mr_sel", {28'b0, eng.sel}, 0);
      chk("mr_err", {28'b0, req_err}, 0);
      chk("mr_rdata", req_rdata, 0);
      repeat (3) step;
      chk("mr_no_done", {28'b0, req_done}, 0);
      chk("mr_no_send", {31'b0, eng.eng_send}, 0);
      req = 4'b0101; req_wdata = 32'h00AA00BB; step; req = '0;
      serve("mr_a", 4'b0001, 8'hBB, 7'h00, 1'b0, 1, 8'h00, n);
      serve("mr_b", 4'b0100, 8'hAA, 7'h00, 1'b0, 1, 8'h00, n);
      // re-request in the completion cycle
      req = 4'b0010; req_reg = 28'h01 << 7; req_wdata = 32'h00007100; step; req = '0;
      serve("rq", 4'b0010, 8'h71, 7'h01, 1'b0, 2, 8'h00, n);
      req = 4'b0010; req_reg = 28'h02 << 7; req_wdata = 32'h00007200; step; req = '0;
      chk("rq_err", {28'b0, req_err}, 0);
      chk("rq_pending", {28'b0, req_pending}, 32'h2);
      step;
      chk("rq_send", {31'b0, eng.eng_send}, 1);
      chk("rq_wdata", {24'b0, eng.eng_wdata}, 32'h72);
      chk("rq_reg", {25'b0, eng.eng_reg}, 32'h02);
      step; eng.eng_done = 1'b1; step; eng.eng_done = 1'b0;
      chk("rq_done", {28'b0, req_done}, 32'h2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
